// File: rtl/booth_operand_scheduler.sv
// Operand FIFO and issue sequencer feeding a radix-4 Booth multiplier,
// with a single-entry result register toward the consumer.
module booth_operand_scheduler #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int CHECK_PARAM = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_multiplier,
  input  logic [WIDTH-1:0]             in_multiplicand,
  output logic                         mul_start,
  output logic                         mul_en,
  output logic [WIDTH-1:0]             mul_multiplier,
  output logic [WIDTH-1:0]             mul_multiplicand,
  input  logic                         mul_ready,
  input  logic [2*WIDTH-1:0]           mul_product,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [2*WIDTH-1:0]           out_product,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  if (CHECK_PARAM != 0) begin : g_check
    if (WIDTH == 0 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad
      $fatal(1, "booth_operand_scheduler: illegal WIDTH/DEPTH");
    end
  end

  typedef enum logic [1:0] {IDLE, ISSUE, ARM, WAIT} state_t;

  state_t state, next_state;

  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]      head, tail;
  logic               push, pop, slot_free;

  assign in_ready  = (count < FULL);
  assign push      = en && in_valid && in_ready;
  assign slot_free = !out_valid || out_ready;
  // Pop and capture are the same event: leaving WAIT with a free result slot.
  assign pop       = en && (state == WAIT) && mul_ready && slot_free;

  assign {mul_multiplier, mul_multiplicand} = mem[head];

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= {in_multiplier, in_multiplicand};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= (tail == LAST) ? '0 : tail + 1'b1;
      if (pop)  head <= (head == LAST) ? '0 : head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_product <= '0;
    end else if (pop) begin
      out_valid   <= 1'b1;
      out_product <= mul_product;
    end else if (en && out_ready) begin
      out_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (en) begin
      case (state)
        IDLE:    if (count != '0) next_state = ISSUE;
        ISSUE:   next_state = ARM;
        ARM:     next_state = WAIT;
        WAIT:    if (mul_ready && slot_free) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    mul_start = en && (state == ISSUE);
    mul_en    = en;
    busy      = (state != IDLE);
  end

endmodule

// File: tb/tb_booth_operand_scheduler.sv
// Scoreboard bench for booth_operand_scheduler with a behavioural
// multiplier that raises done four cycles after each start pulse.
module tb_booth_operand_scheduler;

  logic        clk = 1'b0;
  logic        rst_n, en, in_valid, out_ready;
  logic        in_ready, mul_start, mul_en, mul_ready, out_valid, busy;
  logic [7:0]  in_multiplier, in_multiplicand, mul_multiplier, mul_multiplicand;
  logic [15:0] mul_product, out_product;
  logic [2:0]  count;

  int tests = 0;
  int fails = 0;
  logic [15:0] sb[$];

  always #5 clk = ~clk;

  booth_operand_scheduler #(.WIDTH(8), .DEPTH(4), .CHECK_PARAM(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_multiplier(in_multiplier), .in_multiplicand(in_multiplicand),
    .mul_start(mul_start), .mul_en(mul_en),
    .mul_multiplier(mul_multiplier), .mul_multiplicand(mul_multiplicand),
    .mul_ready(mul_ready), .mul_product(mul_product),
    .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
    .count(count), .busy(busy)
  );

  // Downstream multiplier: signed product, done held until the next start.
  int   mcnt = 0;
  logic mdone = 1'b0;
  logic force_ready = 1'b0;
  logic signed [31:0] pa, pb, pp;

  always @(posedge clk) begin
    if (mul_en) begin
      if (mul_start) begin
        mcnt  <= 3;
        mdone <= 1'b0;
      end else if (mcnt != 0) begin
        mcnt <= mcnt - 1;
        if (mcnt == 1) mdone <= 1'b1;
      end
    end
  end

  always_comb begin
    pa = {{24{mul_multiplier[7]}}, mul_multiplier};
    pb = {{24{mul_multiplicand[7]}}, mul_multiplicand};
    pp = pa * pb;
  end

  assign mul_product = pp[15:0];
  assign mul_ready   = mdone | force_ready;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && en && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got 0x%0h expected none", out_product);
      end else begin
        check("result", {16'h0, out_product}, {16'h0, sb.pop_front()});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] exp, output int waited);
    waited          = 0;
    in_multiplier   = a;
    in_multiplicand = b;
    in_valid        = 1'b1;
    while (!in_ready && waited < 100) begin
      step(1);
      waited++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL push_timeout: got in_ready 0 expected 1");
      in_valid = 1'b0;
      return;
    end
    sb.push_back(exp);
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || busy || out_valid) && n < 300) begin
      step(1);
      n++;
    end
    check("drain_done", {31'h0, n < 300}, 32'h1);
  endtask

  initial begin
    int w;
    rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_multiplier = '0; in_multiplicand = '0;
    step(2);
    check("rst_count", count, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_product", out_product, 0);
    check("rst_busy", busy, 0);
    check("rst_mul_start", mul_start, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;

    // Latency of a single pair: start at cycle 2, capture once done arrives.
    push(8'd7, 8'd6, 16'h002A, w);
    check("lat_c1_count", count, 1);
    check("lat_c1_busy", busy, 0);
    step(1);
    check("lat_c2_start", mul_start, 1);
    check("lat_c2_mplier", mul_multiplier, 7);
    check("lat_c2_mcand", mul_multiplicand, 6);
    step(1);
    check("lat_c3_start", mul_start, 0);
    check("lat_c3_busy", busy, 1);
    step(3);
    check("lat_c6_out_valid", out_valid, 0);
    step(1);
    check("lat_c7_out_valid", out_valid, 1);
    check("lat_c7_product", out_product, 16'h002A);
    check("lat_c7_count", count, 0);
    step(1);
    check("lat_c8_out_valid", out_valid, 0);
    check("lat_c8_busy", busy, 0);

    push(8'hFD, 8'h05, 16'hFFF1, w);
    drain();

    // Fill to full, fifth pair must wait for the first pop.
    push(8'd1, 8'd2, 16'h0002, w);
    push(8'd3, 8'd4, 16'h000C, w);
    push(8'd5, 8'd6, 16'h001E, w);
    push(8'd7, 8'd8, 16'h0038, w);
    check("full_in_ready", in_ready, 0);
    check("full_count", count, 4);
    push(8'd9, 8'd10, 16'h005A, w);
    check("fifth_waited", {31'h0, w != 0}, 32'h1);
    drain();
    check("after_full_count", count, 0);

    // Back-pressure on the result register.
    out_ready = 1'b0;
    push(8'd2, 8'd3, 16'h0006, w);
    push(8'd4, 8'd5, 16'h0014, w);
    step(20);
    check("hold_out_valid", out_valid, 1);
    check("hold_product", out_product, 16'h0006);
    check("hold_count", count, 1);
    check("hold_busy", busy, 1);
    out_ready = 1'b1;
    drain();

    // Reset while waiting with three pairs queued.
    push(8'd1, 8'd1, 16'h0001, w);
    push(8'd2, 8'd2, 16'h0004, w);
    push(8'd3, 8'd3, 16'h0009, w);
    step(1);
    check("prerst_busy", busy, 1);
    check("prerst_count", count, 3);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    sb.delete();
    check("midrst_count", count, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    step(6);
    check("late_ready_seen", {31'h0, mdone}, 32'h1);
    check("late_out_valid", out_valid, 0);
    check("late_busy", busy, 0);
    check("late_count", count, 0);

    // Enable low for three cycles while in ARM, with a stale done present.
    push(8'd11, 8'd3, 16'h0021, w);
    step(1);
    check("en_issue_start", mul_start, 1);
    step(1);
    en = 1'b0;
    force_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("en_off_busy", busy, 1);
      check("en_off_start", mul_start, 0);
      check("en_off_count", count, 1);
      check("en_off_in_ready", in_ready, 1);
      check("en_off_out_valid", out_valid, 0);
    end
    en = 1'b1;
    step(1);
    check("en_resume_arm_masks", out_valid, 0);
    step(1);
    check("en_resume_capture", out_valid, 1);
    check("en_resume_product", out_product, 16'h0021);
    force_ready = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
